hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard/sequencing controller for the 5-stage MIPS pipeline. Drives the
//  stall, flush and forwarding controls of the F/D, D/E, E/M and M/W pipeline latches.
//  Covers load-use and branch-compare hazards, and data-memory wait states on a
//  req/ready handshake with a timeout. Sits beside the datapath; owns no data.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles in MEM_WAIT before MEM_ERR (>=2)
//  CNT_W        32  width of saturating stall-cycle counter
// PORTS
//  clk           in   1   clock, all state on posedge
//  reset         in   1   asynchronous, active-high; clears all state
//  RsD,RtD       in   5   source regs in Decode
//  RsE,RtE       in   5   source regs in Execute
//  WriteRegE/M/W in   5   dest reg in E/M/W
//  RegWriteE/M/W in   1   dest write enable in E/M/W
//  MemtoRegE/M   in   1   load in E/M
//  BranchD       in   1   branch resolving in Decode
//  MemAccessM    in   1   load or store in Memory stage
//  mem_ready     in   1   data memory completes access this cycle
//  mem_req       out  1   data memory request
//  StallF,StallD out  1   hold PC / F-D latch
//  StallE,StallM out  1   hold D-E / E-M latch
//  FlushE        out  1   bubble into D-E latch (zero controls)
//  FlushW        out  1   bubble into M-W latch (RegWriteW<=0 next edge)
//  ForwardAE,BE  out  2   00 regfile, 01 from W result, 10 from ALUOutM
//  ForwardAD,BD  out  1   branch operand from ALUOutM
//  mem_err       out  1   sticky memory timeout flag
//  stall_cycles  out  CNT_W  count of cycles with StallF=1, saturates at all-ones
// BEHAVIOUR
//  Reset: state=RUN, timer=0, mem_err=0, stall_cycles=0; all outputs combinational
//   from that state, so with quiet inputs every output = 0.
//  FSM: RUN, MEM_WAIT, MEM_ERR (registered state, 2-bit).
//   RUN: mem_req=MemAccessM. If MemAccessM & !mem_ready -> MEM_WAIT, timer<=1.
//        If mem_ready in the same cycle: zero-latency, no stall.
//   MEM_WAIT: mem_req=1; StallF/D/E/M=1; FlushW=1. mem_ready -> RUN with stalls
//        released that cycle (combinational off ready). Else timer++;
//        timer==MEM_TIMEOUT-1 & !mem_ready -> MEM_ERR.
//   MEM_ERR: mem_req=0, StallF/D/E/M=1, FlushW=1, mem_err=1; leave only by reset.
//  Forwarding (combinational, rs!=0 required):
//   ForwardAE=10 if RegWriteM & WriteRegM==RsE; else 01 if RegWriteW & WriteRegW==RsE;
//   else 00. M beats W when both match. Same for BE/RtE.
//   ForwardAD = RegWriteM & WriteRegM==RsD & RsD!=0; BD likewise with RtD.
//  Hazards in RUN only (suppressed in MEM_WAIT/MEM_ERR; memory stall dominates):
//   lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
//   brstall = BranchD & ((RegWriteE & WriteRegE in {RsD,RtD}) |
//             (MemtoRegM & WriteRegM in {RsD,RtD})); zero register excluded.
//   lwstall|brstall -> StallF=StallD=FlushE=1, StallE=StallM=0.
//  In MEM_WAIT, FlushE=0; D-E is held, not bubbled.
//  stall_cycles increments on every cycle StallF=1, holds at max.
//  Async reset mid-MEM_WAIT: back to RUN immediately; mem_req drops without ready.
// STRUCTURE
//  Shared pkg pipe_pkg: FSM state encoding, FWD_RF/FWD_W/FWD_M 2-bit constants.
//  One sub-module natural: fwd_unit (purely combinational forwarding compare),
//  instantiated once for E and once for D. FSM, timer, and counter stay in the top.
// TESTING
//  1 reset mid-wait: reset asserted in MEM_WAIT -> same cycle: mem_req=0, stalls=0;
//    stall_cycles=0.
//  2 forward: RegWriteM=1,WriteRegM=8,RegWriteW=1,WriteRegW=8,RsE=8 -> ForwardAE=10;
//    RsE=0, all dest regs 0 -> ForwardAE=00.
//  3 load-use: MemtoRegE=1,RtE=9,RsD=9 -> StallF=StallD=FlushE=1 for exactly 1 cycle.
//  4 branch: BranchD=1,RsD=5,RegWriteE=1,WriteRegE=5 -> stall 1 cycle; next cycle
//    (value in M) ForwardAD=1, no stall.
//  5 mem wait: MemAccessM=1,mem_ready low 3 cycles then high -> StallF/D/E/M and
//    FlushW high 3 cycles; stall_cycles=3; RUN after.
//  6 timeout: MEM_TIMEOUT=4, mem_ready never -> MEM_ERR after 4 cycles, mem_req=0,
//    mem_err=1 and stalls held until reset.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: memory FSM encoding,
// forwarding-select codes and a register-match helper.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_MEM_ERR  = 2'd2
   } state_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   // $zero is never a real producer, so it can never match a consumer.
   function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
      return (dst != 5'd0) && (dst == src);
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational forwarding select for one pair of source operands.
// The Memory-stage producer is newer, so it wins over Writeback.
module fwd_unit
   import pipe_pkg::*;
(
   input  logic [4:0] rs_i,
   input  logic [4:0] rt_i,
   input  logic       reg_write_m_i,
   input  logic [4:0] write_reg_m_i,
   input  logic       reg_write_w_i,
   input  logic [4:0] write_reg_w_i,
   output logic [1:0] fwd_a_o,
   output logic [1:0] fwd_b_o
);

   always_comb begin
      fwd_a_o = FWD_RF;
      fwd_b_o = FWD_RF;
      if (reg_write_m_i && reg_match(write_reg_m_i, rs_i)) begin
         fwd_a_o = FWD_M;
      end else if (reg_write_w_i && reg_match(write_reg_w_i, rs_i)) begin
         fwd_a_o = FWD_W;
      end else begin
         fwd_a_o = FWD_RF;
      end
      if (reg_write_m_i && reg_match(write_reg_m_i, rt_i)) begin
         fwd_b_o = FWD_M;
      end else if (reg_write_w_i && reg_match(write_reg_w_i, rt_i)) begin
         fwd_b_o = FWD_W;
      end else begin
         fwd_b_o = FWD_RF;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: forwarding,
// load-use and branch stalls, and data-memory wait states with timeout.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic [4:0]       RsE,
   input  logic [4:0]       RtE,
   input  logic [4:0]       WriteRegE,
   input  logic [4:0]       WriteRegM,
   input  logic [4:0]       WriteRegW,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             MemtoRegM,
   input  logic             BranchD,
   input  logic             MemAccessM,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             ForwardAD,
   output logic             ForwardBD,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int TW = $clog2(MEM_TIMEOUT) + 1;

   state_e           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_s, mem_stall_s, err_s, lwstall_s, brstall_s, haz_s;
   logic [1:0]       fwd_ad_s, fwd_bd_s;

   fwd_unit u_fwd_e (
      .rs_i          (RsE),
      .rt_i          (RtE),
      .reg_write_m_i (RegWriteM),
      .write_reg_m_i (WriteRegM),
      .reg_write_w_i (RegWriteW),
      .write_reg_w_i (WriteRegW),
      .fwd_a_o       (ForwardAE),
      .fwd_b_o       (ForwardBE)
   );

   // Branch compare in Decode only has a bypass from ALUOutM.
   fwd_unit u_fwd_d (
      .rs_i          (RsD),
      .rt_i          (RtD),
      .reg_write_m_i (RegWriteM),
      .write_reg_m_i (WriteRegM),
      .reg_write_w_i (1'b0),
      .write_reg_w_i (5'd0),
      .fwd_a_o       (fwd_ad_s),
      .fwd_b_o       (fwd_bd_s)
   );

   assign ForwardAD = (fwd_ad_s == FWD_M);
   assign ForwardBD = (fwd_bd_s == FWD_M);

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      req_s       = 1'b0;
      mem_stall_s = 1'b0;
      err_s       = 1'b0;
      case (state_q)
         ST_RUN: begin
            req_s       = MemAccessM;
            mem_stall_s = MemAccessM && !mem_ready;
            if (mem_stall_s) begin
               state_d = ST_MEM_WAIT;
               timer_d = TW'(1);
            end else begin
               timer_d = '0;
            end
         end
         ST_MEM_WAIT: begin
            req_s       = 1'b1;
            mem_stall_s = !mem_ready;
            if (mem_ready) begin
               state_d = ST_RUN;
               timer_d = '0;
            end else if (timer_q == TW'(MEM_TIMEOUT - 1)) begin
               state_d = ST_MEM_ERR;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_MEM_ERR: begin
            mem_stall_s = 1'b1;
            err_s       = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
            timer_d = '0;
         end
      endcase

      lwstall_s = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
      brstall_s = BranchD &&
                  ((RegWriteE && (reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD))) ||
                   (MemtoRegM && (reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD))));
      haz_s     = (state_q == ST_RUN) && !mem_stall_s && (lwstall_s || brstall_s);

      // Outputs are forced quiet while reset is held, even if inputs are not.
      mem_req = !reset && req_s;
      StallF  = !reset && (mem_stall_s || haz_s);
      StallD  = StallF;
      StallE  = !reset && mem_stall_s;
      StallM  = StallE;
      FlushW  = StallE;
      FlushE  = !reset && haz_s;
      mem_err = !reset && err_s;

      cnt_d = cnt_q;
      if (StallF && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign stall_cycles = cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         timer_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised and directed check of hazard_ctrl against a cycle-level
// behavioural model of the pipeline control rules.
module tb_hazard_ctrl;

   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_W       = 6;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD;
   logic MemAccessM, mem_ready;
   logic mem_req, StallF, StallD, StallE, StallM, FlushE, FlushW;
   logic [1:0] ForwardAE, ForwardBE;
   logic ForwardAD, ForwardBD, mem_err;
   logic [CNT_W-1:0] stall_cycles;

   hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
      .MemAccessM(MemAccessM), .mem_ready(mem_ready), .mem_req(mem_req),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .mem_err(mem_err), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   int vectors   = 0;
   int miscompares = 0;

   // model state: an access is outstanding, how many stalled cycles it has used, dead memory
   bit m_in_wait = 1'b0;
   int m_waited  = 0;
   bit m_err     = 1'b0;
   int m_cnt     = 0;

   // DUT outputs as seen at the last compare
   logic s_req, s_sf, s_se, s_fe, s_fw, s_err, s_ad;
   logic [1:0] s_ae;
   logic [CNT_W-1:0] s_cnt;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd_model(input logic [4:0] r, input logic wm, input logic [4:0] dm,
                                            input logic ww, input logic [4:0] dw);
      if (r == 5'd0) return 2'b00;
      if (wm && dm == r) return 2'b10;
      if (ww && dw == r) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic hits(input logic [4:0] d);
      return (d != 5'd0) && (d == RsD || d == RtD);
   endfunction

   // One clock: compare every output against the model at negedge, then advance the model.
   task automatic step();
      logic active, memst, lw, br, haz, e_sf;
      @(negedge clk);
      if (reset) begin
         m_in_wait = 1'b0; m_waited = 0; m_err = 1'b0; m_cnt = 0;
      end
      active = !reset && !m_err && (m_in_wait || MemAccessM);
      memst  = !reset && (m_err || (active && !mem_ready));
      lw     = MemtoRegE && (RtE == RsD || RtE == RtD);
      br     = BranchD && ((RegWriteE && hits(WriteRegE)) || (MemtoRegM && hits(WriteRegM)));
      haz    = !reset && !m_err && !m_in_wait && !memst && (lw || br);
      e_sf   = memst || haz;

      s_req = mem_req; s_sf = StallF; s_se = StallE; s_fe = FlushE; s_fw = FlushW;
      s_err = mem_err; s_ad = ForwardAD; s_ae = ForwardAE; s_cnt = stall_cycles;

      chk("mem_req", 64'(mem_req), 64'(active));
      chk("StallF",  64'(StallF),  64'(e_sf));
      chk("StallD",  64'(StallD),  64'(e_sf));
      chk("StallE",  64'(StallE),  64'(memst));
      chk("StallM",  64'(StallM),  64'(memst));
      chk("FlushE",  64'(FlushE),  64'(haz));
      chk("FlushW",  64'(FlushW),  64'(memst));
      chk("mem_err", 64'(mem_err), 64'(!reset && m_err));
      chk("ForwardAE", 64'(ForwardAE), 64'(fwd_model(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW)));
      chk("ForwardBE", 64'(ForwardBE), 64'(fwd_model(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW)));
      chk("ForwardAD", 64'(ForwardAD), 64'(fwd_model(RsD, RegWriteM, WriteRegM, 1'b0, 5'd0) == 2'b10));
      chk("ForwardBD", 64'(ForwardBD), 64'(fwd_model(RtD, RegWriteM, WriteRegM, 1'b0, 5'd0) == 2'b10));
      chk("stall_cycles", 64'(stall_cycles), 64'(m_cnt));

      @(posedge clk);
      if (!reset) begin
         if (e_sf && m_cnt < CNT_MAX) m_cnt++;
         if (!m_err && active) begin
            if (mem_ready) begin
               m_in_wait = 1'b0; m_waited = 0;
            end else begin
               m_waited++;
               if (m_waited == MEM_TIMEOUT) begin
                  m_err = 1'b1; m_in_wait = 1'b0;
               end else begin
                  m_in_wait = 1'b1;
               end
            end
         end
      end
      #1;
   endtask

   task automatic quiet();
      RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
      WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
      RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      MemtoRegE = 1'b0; MemtoRegM = 1'b0; BranchD = 1'b0;
      MemAccessM = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; step(); reset = 1'b0;
   endtask

   initial begin
      quiet();
      reset = 1'b1;
      step();
      chk("reset_StallF", 64'(s_sf), 64'(0));
      chk("reset_req", 64'(s_req), 64'(0));
      reset = 1'b0;

      // reset while waiting on memory
      MemAccessM = 1'b1; mem_ready = 1'b0;
      step(); step();
      chk("wait_StallE", 64'(s_se), 64'(1));
      reset = 1'b1;
      step();
      chk("rstwait_req", 64'(s_req), 64'(0));
      chk("rstwait_StallF", 64'(s_sf), 64'(0));
      chk("rstwait_cnt", 64'(s_cnt), 64'(0));
      reset = 1'b0; quiet();

      // forwarding priority and the zero register
      RegWriteM = 1'b1; WriteRegM = 5'd8; RegWriteW = 1'b1; WriteRegW = 5'd8; RsE = 5'd8;
      step();
      chk("fwd_M_wins", 64'(s_ae), 64'(2'b10));
      RegWriteW = 1'b1; WriteRegW = 5'd7; RegWriteM = 1'b0; RsE = 5'd7;
      step();
      chk("fwd_W", 64'(s_ae), 64'(2'b01));
      quiet(); RegWriteM = 1'b1; RegWriteW = 1'b1;
      step();
      chk("fwd_zero", 64'(s_ae), 64'(2'b00));
      quiet();

      // load-use: one bubble, then the load has moved on
      MemtoRegE = 1'b1; RtE = 5'd9; RsD = 5'd9;
      step();
      chk("lw_StallF", 64'(s_sf), 64'(1));
      chk("lw_FlushE", 64'(s_fe), 64'(1));
      chk("lw_StallE", 64'(s_se), 64'(0));
      quiet(); RsD = 5'd9;
      step();
      chk("lw_release", 64'(s_sf), 64'(0));
      quiet();

      // branch compare waits for ALU result, then takes it from M
      BranchD = 1'b1; RsD = 5'd5; RegWriteE = 1'b1; WriteRegE = 5'd5;
      step();
      chk("br_StallF", 64'(s_sf), 64'(1));
      RegWriteE = 1'b0; WriteRegE = 5'd0; RegWriteM = 1'b1; WriteRegM = 5'd5;
      step();
      chk("br_ForwardAD", 64'(s_ad), 64'(1));
      chk("br_nostall", 64'(s_sf), 64'(0));
      quiet();

      // three wait states, released combinationally on ready
      do_reset();
      MemAccessM = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("memwait_StallF", 64'(s_sf), 64'(1));
         chk("memwait_FlushW", 64'(s_fw), 64'(1));
      end
      mem_ready = 1'b1;
      step();
      chk("memready_StallF", 64'(s_sf), 64'(0));
      chk("memready_cnt", 64'(s_cnt), 64'(3));
      quiet();
      step();
      chk("memrun_req", 64'(s_req), 64'(0));

      // timeout to sticky error, counter saturates while dead
      do_reset();
      MemAccessM = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < MEM_TIMEOUT; i++) begin
         step();
         chk("tmo_req", 64'(s_req), 64'(1));
         chk("tmo_err", 64'(s_err), 64'(0));
      end
      step();
      chk("err_flag", 64'(s_err), 64'(1));
      chk("err_req", 64'(s_req), 64'(0));
      MemAccessM = 1'b0; mem_ready = 1'b1;
      for (int i = 0; i < CNT_MAX + 8; i++) step();
      chk("err_held", 64'(s_sf), 64'(1));
      chk("cnt_saturated", 64'(s_cnt), 64'(CNT_MAX));
      do_reset();

      // random traffic over a small register set so hazards are frequent
      for (int n = 0; n < 2000; n++) begin
         RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
         RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
         WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
         WriteRegW = 5'($urandom_range(0, 3));
         RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
         RegWriteW = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
         MemtoRegM = 1'($urandom_range(0, 1)); BranchD = 1'($urandom_range(0, 1));
         MemAccessM = ($urandom_range(0, 2) == 0);
         mem_ready = 1'($urandom_range(0, 1));
         reset = ($urandom_range(0, 39) == 0);
         step();
      end
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
